irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter: N_SRC, default 8, number of interrupt sources (1..8).
REQ-002 Port: clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  reset, asynchronous and active-low.
REQ-004 Port: CS_N  input  1  chip select, active-low, driven by the address decoder.
REQ-005 Port: RD_N  input  1  read strobe, active-low.
REQ-006 Port: WR_N  input  1  write strobe, active-low.
REQ-007 Port: Addr  input  12  byte address within the block; bits [4:2] select the register.
REQ-008 Port: DataIn  input  32  write data.
REQ-009 Port: DataOut  output  32  read data.
REQ-010 Port: irq_src_n  input  N_SRC  raw peripheral interrupt lines (timer Intr, UART IntRx_N/IntTx_N, GPIO Intr); same clock domain.
REQ-011 Port: nIRQ  output  1  interrupt request to the CPU, active-low, registered.

Function
REQ-012 Register map (word offsets):
- 0x00 RAW (RO): active levels.
- 0x04 PEND (R/W1C).
- 0x08 ENABLE (RW).
- 0x0C MODE (RW): 1=edge, 0=level.
- 0x10 POL (RW): 1=active-high, 0=active-low.
- 0x14 VECTOR (RO).
- 0x18 SWSET (WO): write-1-to-set PEND.
- 0x1C CTRL (RW): bit0 = global enable GIE.
REQ-013 Active level per source: act[i] = irq_src_n[i] XNOR POL[i].
REQ-014 A register act_q SHALL capture act every cycle; RAW reads act_q.
REQ-015 Edge-mode rise[i] = act[i] AND NOT act_q[i]; a rise sets PEND[i] at that clock edge.
REQ-016 Level-mode PEND[i] SHALL equal act[i] registered each cycle; W1C and SWSET writes to level-mode bits are ignored.
REQ-017 Write decode: a write occurs on a rising clk when CS_N=0 and WR_N=0; bits above N_SRC-1 are ignored; unused offsets are ignored.
REQ-018 Edge-mode PEND bit update in the same cycle:
- set (rise or SWSET) takes priority over W1C clear;
- otherwise W1C clears the bit;
- otherwise the bit holds.
REQ-019 Clearing MODE[i] to level SHALL reload PEND[i] from act[i] on the next edge; setting MODE[i] to edge SHALL hold PEND[i] and require a new rise to set it.
REQ-020 Writing POL can create a rise; that rise SHALL set PEND like any other rise.
REQ-021 Reads are combinational: DataOut = selected register when CS_N=0 and RD_N=0, else 32'h0; unused bits and unused offsets read 0.
REQ-022 Reads have no side effects (no read-to-clear).
REQ-023 VECTOR: bit31 = 1 if any (PEND AND ENABLE) bit is set; bits[2:0] = lowest-numbered such source; reads 32'h0 when none.
REQ-024 nIRQ SHALL be registered as nIRQ <= NOT(GIE AND |(PEND AND ENABLE)).
REQ-025 Latency: a source asserting before clk edge k sets PEND after edge k and drives nIRQ low after edge k+1 (2-cycle latency).
REQ-026 nIRQ deasserts one edge after the last enabled pending bit clears, or one edge after GIE or ENABLE is written 0.
REQ-027 ENABLE gates only nIRQ and VECTOR; PEND captures events regardless of ENABLE and GIE.

Reset
REQ-028 While reset=0, asynchronously:
- PEND, ENABLE, MODE, POL, GIE = 0;
- act_q = 0 (with POL=0, an idle-high line gives act=0, so no false edge on release);
- nIRQ = 1.
REQ-029 DataOut SHALL read 0 during reset; reset asserted mid-operation discards all pending events.
REQ-030 The first rising clk after reset release follows the normal update rules; rises on that edge are captured.

Verification
REQ-031 Edge capture and latency:
- Stimulus: MODE=0xFF, POL=0, ENABLE=0x01, GIE=1; pulse irq_src_n[0] low for 1 cycle.
- Response: PEND=0x01 after edge k, nIRQ=0 after edge k+1, VECTOR=32'h8000_0000.
- Then write PEND=0x01: nIRQ returns to 1 one cycle later.
REQ-032 Priority:
- Stimulus: sources 5 and 2 pending, ENABLE=0x24.
- Response: VECTOR=32'h8000_0002; after W1C of bit 2, VECTOR=32'h8000_0005.
REQ-033 Set/clear collision: a rise on source 3 in the same cycle as a W1C write of 0x08 leaves PEND[3]=1.
REQ-034 Level mode: MODE[1]=0 with irq_src_n[1] held low.
- W1C of 0x02 leaves PEND[1]=1.
- Releasing the line clears PEND[1] one cycle later.
REQ-035 Masking and software set:
- SWSET=0x80 with ENABLE=0: nIRQ stays 1 and VECTOR=0.
- Writing ENABLE=0x80 then drives nIRQ=0 one cycle later.
REQ-036 Reset mid-operation: with nIRQ=0 and PEND=0xFF, asserting reset forces nIRQ=1 and all registers to 0 immediately, without a clock edge.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// irq_ctrl_if -- peripheral register bus between the address decoder/CPU and
// the interrupt controller.
//
// Signals:
//   CS_N    chip select, active-low (from the address decoder)
//   RD_N    read strobe, active-low
//   WR_N    write strobe, active-low
//   Addr    byte address within the block, bits [4:2] pick the register
//   DataIn  write data
//   DataOut read data (combinational)
//
// Bus semantics: there is no valid/ready pair. A write is accepted on every
// rising clk where CS_N=0 and WR_N=0 (always ready, single-cycle). A read is
// purely combinational: DataOut shows the selected register while CS_N=0 and
// RD_N=0, and 0 otherwise; reads never change state.
`timescale 1ns/1ps
interface irq_ctrl_if;
  logic        CS_N;
  logic        RD_N;
  logic        WR_N;
  logic [11:0] Addr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;

  modport master (
    output CS_N,
    output RD_N,
    output WR_N,
    output Addr,
    output DataIn,
    input  DataOut
  );

  modport slave (
    input  CS_N,
    input  RD_N,
    input  WR_N,
    input  Addr,
    input  DataIn,
    output DataOut
  );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl -- interrupt controller for up to 8 peripheral sources.
//
// Each source is normalised by its POL bit into an active level, captured in
// PEND either as a level (follows the line) or as an edge (sticky until
// cleared by a write-1-to-clear). Enabled pending sources raise the registered
// active-low nIRQ when the global enable is set; VECTOR reports the
// lowest-numbered enabled pending source.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   reset      asynchronous, active-low reset
//   bus        register bus (irq_ctrl_if.slave): CS_N, RD_N, WR_N, Addr,
//              DataIn, DataOut
//   irq_src_n  raw peripheral interrupt lines, same clock domain
//   nIRQ       registered interrupt request to the CPU, active-low
//
// Register map (word offsets, Addr[4:2]):
//   0x00 RAW    RO    captured active levels (act_q)
//   0x04 PEND   R/W1C
//   0x08 ENABLE RW
//   0x0C MODE   RW    1=edge, 0=level
//   0x10 POL    RW    1=active-high, 0=active-low
//   0x14 VECTOR RO    bit31=any, bits[2:0]=lowest enabled pending source
//   0x18 SWSET  WO    write-1-to-set PEND (edge-mode bits only)
//   0x1C CTRL   RW    bit0 = GIE
`timescale 1ns/1ps
module irq_ctrl #(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             reset,
  irq_ctrl_if.slave        bus,
  input  logic [N_SRC-1:0] irq_src_n,
  output logic             nIRQ
);

  localparam logic [2:0] REG_RAW    = 3'd0;
  localparam logic [2:0] REG_PEND   = 3'd1;
  localparam logic [2:0] REG_ENABLE = 3'd2;
  localparam logic [2:0] REG_MODE   = 3'd3;
  localparam logic [2:0] REG_POL    = 3'd4;
  localparam logic [2:0] REG_VECTOR = 3'd5;
  localparam logic [2:0] REG_SWSET  = 3'd6;
  localparam logic [2:0] REG_CTRL   = 3'd7;

  // State
  logic [N_SRC-1:0] act_q;
  logic [N_SRC-1:0] pend_q,  pend_d;
  logic [N_SRC-1:0] en_q,    en_d;
  logic [N_SRC-1:0] mode_q,  mode_d;
  logic [N_SRC-1:0] pol_q,   pol_d;
  logic             gie_q,   gie_d;
  logic             irq_n_q, irq_n_d;

  // Combinational helpers
  logic             wr_en;
  logic             rd_en;
  logic [2:0]       sel;
  logic [N_SRC-1:0] wdata;
  logic [N_SRC-1:0] act;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] w1c;
  logic [N_SRC-1:0] swset;
  logic [N_SRC-1:0] masked;
  logic             any_irq;
  logic [2:0]       vec_idx;
  logic [31:0]      vector;
  logic [31:0]      rdata;

  assign wr_en = ~bus.CS_N & ~bus.WR_N;
  assign rd_en = ~bus.CS_N & ~bus.RD_N;
  assign sel   = bus.Addr[4:2];
  // Bits above N_SRC-1 are dropped here, so they can never reach state.
  assign wdata = bus.DataIn[N_SRC-1:0];

  // Polarity-normalised level: XNOR makes POL=1 pass the line through and
  // POL=0 invert an active-low line.
  assign act  = ~(irq_src_n ^ pol_q);
  // A POL write also changes act, so it can produce a rise like any source.
  assign rise = act & ~act_q;

  assign w1c   = (wr_en && (sel == REG_PEND))  ? wdata : '0;
  assign swset = (wr_en && (sel == REG_SWSET)) ? wdata : '0;

  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < N_SRC; i++) begin
      if (mode_q[i]) begin
        // Edge mode: a set in the same cycle wins over a W1C clear.
        if (rise[i] || swset[i]) begin
          pend_d[i] = 1'b1;
        end else if (w1c[i]) begin
          pend_d[i] = 1'b0;
        end else begin
          pend_d[i] = pend_q[i];
        end
      end else begin
        // Level mode tracks the line; W1C/SWSET have no effect here.
        // Using mode_q means a MODE change takes effect from the next edge.
        pend_d[i] = act[i];
      end
    end
  end

  always_comb begin
    en_d   = en_q;
    mode_d = mode_q;
    pol_d  = pol_q;
    gie_d  = gie_q;
    if (wr_en) begin
      case (sel)
        REG_ENABLE: en_d   = wdata;
        REG_MODE:   mode_d = wdata;
        REG_POL:    pol_d  = wdata;
        REG_CTRL:   gie_d  = bus.DataIn[0];
        default:    ;
      endcase
    end
  end

  // ENABLE gates only the request and the vector, never capture.
  assign masked  = pend_q & en_q;
  assign any_irq = |masked;

  // Scan from the top down so the lowest-numbered source is the last writer.
  always_comb begin
    vec_idx = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (masked[i]) begin
        vec_idx = 3'(i);
      end
    end
  end

  assign vector  = any_irq ? {1'b1, 28'h0, vec_idx} : 32'h0;
  assign irq_n_d = ~(gie_q & any_irq);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_q   <= '0;
      pend_q  <= '0;
      en_q    <= '0;
      mode_q  <= '0;
      pol_q   <= '0;
      gie_q   <= 1'b0;
      irq_n_q <= 1'b1;
    end else begin
      act_q   <= act;
      pend_q  <= pend_d;
      en_q    <= en_d;
      mode_q  <= mode_d;
      pol_q   <= pol_d;
      gie_q   <= gie_d;
      irq_n_q <= irq_n_d;
    end
  end

  assign nIRQ = irq_n_q;

  // Read mux; SWSET is write-only and reads 0.
  always_comb begin
    rdata = 32'h0;
    case (sel)
      REG_RAW:    rdata = 32'(act_q);
      REG_PEND:   rdata = 32'(pend_q);
      REG_ENABLE: rdata = 32'(en_q);
      REG_MODE:   rdata = 32'(mode_q);
      REG_POL:    rdata = 32'(pol_q);
      REG_VECTOR: rdata = vector;
      REG_SWSET:  rdata = 32'h0;
      REG_CTRL:   rdata = {31'h0, gie_q};
      default:    rdata = 32'h0;
    endcase
  end

  // Forced to 0 while reset is held, independent of register contents.
  assign bus.DataOut = (rd_en && reset) ? rdata : 32'h0;

endmodule

// File: tb/tb_irq_ctrl.sv
`timescale 1ns/1ps
module tb_irq_ctrl;

  localparam logic [11:0] A_RAW    = 12'h000;
  localparam logic [11:0] A_PEND   = 12'h004;
  localparam logic [11:0] A_ENABLE = 12'h008;
  localparam logic [11:0] A_MODE   = 12'h00C;
  localparam logic [11:0] A_POL    = 12'h010;
  localparam logic [11:0] A_VECTOR = 12'h014;
  localparam logic [11:0] A_SWSET  = 12'h018;
  localparam logic [11:0] A_CTRL   = 12'h01C;

  logic       clk;
  logic       reset;
  logic [7:0] irq_src_n;
  logic       nIRQ;

  irq_ctrl_if bus_if ();

  irq_ctrl #(.N_SRC(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if.slave),
    .irq_src_n (irq_src_n),
    .nIRQ      (nIRQ)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got;
  logic [31:0] exp;

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors + 1);
    $fatal(1, "watchdog expired");
  end

  // Driver tasks: inputs change on the falling edge, so every rising edge
  // sees stable values.
  task automatic bus_idle();
    bus_if.CS_N   = 1'b1;
    bus_if.RD_N   = 1'b1;
    bus_if.WR_N   = 1'b1;
    bus_if.Addr   = 12'h0;
    bus_if.DataIn = 32'h0;
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.CS_N   = 1'b0;
    bus_if.WR_N   = 1'b0;
    bus_if.Addr   = a;
    bus_if.DataIn = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
    bus_if.CS_N = 1'b0;
    bus_if.RD_N = 1'b0;
    bus_if.Addr = a;
    #1;
    d = bus_if.DataOut;
    bus_idle();
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    irq_src_n = 8'hFF;
    bus_idle();
    repeat (2) @(negedge clk);
    exp_q.push_back(32'h1);
    got = {31'h0, nIRQ};
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_nirq: got %h expected %h", got, exp); end
    exp_q.push_back(32'h0);
    bus_read(A_CTRL, got);
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_dataout: got %h expected %h", got, exp); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    exp_q.push_back(32'h0);
    bus_read(A_PEND, got);
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_pend: got %h expected %h", got, exp); end
    exp_q.push_back(32'h1);
    got = {31'h0, nIRQ};
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_release_nirq: got %h expected %h", got, exp); end
  endtask

  task automatic test_edge_latency();
    bus_write(A_MODE,   32'hFF);
    bus_write(A_POL,    32'h00);
    bus_write(A_ENABLE, 32'h01);
    bus_write(A_CTRL,   32'h01);
    irq_src_n[0] = 1'b0;           // rises before edge k
    @(negedge clk);                // after edge k
    irq_src_n[0] = 1'b1;
    exp_q.push_back(32'h1);
    bus_read(A_PEND, got);
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL edge_pend_k: got %h expected %h", got, exp); end
    exp_q.push_back(32'h1);
    got = {31'h0, nIRQ};
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL edge_nirq_k: got %h expected %h", got, exp); end
    @(negedge clk);                // after edge k+1
    exp_q.push_back(32'h0);
    got = {31'h0, nIRQ};
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL edge_nirq_k1: got %h expected %h", got, exp); end
    exp_q.push_back(32'h8000_0000);
    bus_read(A_VECTOR, got);
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL edge_vector: got %h expected %h", got, exp); end
    bus_write(A_PEND, 32'h01);
    exp_q.push_back(32'h0);
    got = {31'h0, nIRQ};
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL w1c_nirq_same: got %h expected %h", got, exp); end
    @(negedge clk);
    exp_q.push_back(32'h1);
    got = {31'h0, nIRQ};
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL w1c_nirq_next: got %h expected %h", got, exp); end
  endtask

  task automatic test_priority();
    bus_write(A_SWSET,  32'h24);
    bus_write(A_ENABLE, 32'h24);
    exp_q.push_back(32'h8000_0002);
    bus_read(A_VECTOR, got);
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL prio_vector_2: got %h expected %h", got, exp); end
    bus_write(A_PEND, 32'h04);
    exp_q.push_back(32'h8000_0005);
    bus_read(A_VECTOR, got);
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL prio_vector_5: got %h expected %h", got, exp); end
    bus_write(A_PEND, 32'h20);
  endtask

  task automatic test_collision();
    @(negedge clk);
    irq_src_n[3]  = 1'b0;          // rise and W1C hit the same edge
    bus_if.CS_N   = 1'b0;
    bus_if.WR_N   = 1'b0;
    bus_if.Addr   = A_PEND;
    bus_if.DataIn = 32'h08;
    @(negedge clk);
    bus_idle();
    irq_src_n[3] = 1'b1;
    exp_q.push_back(32'h08);
    bus_read(A_PEND, got);
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL collision_pend: got %h expected %h", got, exp); end
    bus_write(A_PEND, 32'h08);
    exp_q.push_back(32'h00);
    bus_read(A_PEND, got);
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL collision_clear: got %h expected %h", got, exp); end
  endtask

  task automatic test_level();
    bus_write(A_MODE, 32'hFD);
    irq_src_n[1] = 1'b0;
    @(negedge clk);
    bus_write(A_PEND, 32'h02);
    exp_q.push_back(32'h02);
    bus_read(A_PEND, got);
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL level_w1c_ignored: got %h expected %h", got, exp); end
    irq_src_n[1] = 1'b1;
    @(negedge clk);
    exp_q.push_back(32'h00);
    bus_read(A_PEND, got);
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL level_release: got %h expected %h", got, exp); end
    bus_write(A_MODE, 32'hFF);
  endtask

  task automatic test_mask_swset();
    bus_write(A_ENABLE, 32'h00);
    bus_write(A_SWSET,  32'h80);
    @(negedge clk);
    exp_q.push_back(32'h1);
    got = {31'h0, nIRQ};
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL mask_nirq: got %h expected %h", got, exp); end
    exp_q.push_back(32'h0);
    bus_read(A_VECTOR, got);
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL mask_vector: got %h expected %h", got, exp); end
    exp_q.push_back(32'h80);
    bus_read(A_PEND, got);
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL swset_pend: got %h expected %h", got, exp); end
    exp_q.push_back(32'h0);
    bus_read(A_SWSET, got);
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL swset_readback: got %h expected %h", got, exp); end
    bus_write(A_ENABLE, 32'h80);
    exp_q.push_back(32'h1);
    got = {31'h0, nIRQ};
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL unmask_nirq_same: got %h expected %h", got, exp); end
    @(negedge clk);
    exp_q.push_back(32'h0);
    got = {31'h0, nIRQ};
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL unmask_nirq_next: got %h expected %h", got, exp); end
    exp_q.push_back(32'h8000_0007);
    bus_read(A_VECTOR, got);
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL unmask_vector: got %h expected %h", got, exp); end
  endtask

  task automatic test_pol();
    bus_write(A_POL, 32'h40);      // idle-high line 6 becomes active
    @(negedge clk);
    exp_q.push_back(32'hC0);
    bus_read(A_PEND, got);
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL pol_rise_pend: got %h expected %h", got, exp); end
    exp_q.push_back(32'h40);
    bus_read(A_RAW, got);
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL pol_raw: got %h expected %h", got, exp); end
  endtask

  task automatic test_reset_mid();
    logic [11:0] addrs [6];
    addrs = '{A_RAW, A_PEND, A_ENABLE, A_MODE, A_POL, A_CTRL};
    bus_write(A_SWSET,  32'hFF);
    bus_write(A_ENABLE, 32'hFF);
    @(negedge clk);
    exp_q.push_back(32'h0);
    got = {31'h0, nIRQ};
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL mid_pre_nirq: got %h expected %h", got, exp); end
    exp_q.push_back(32'hFF);
    bus_read(A_PEND, got);
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL mid_pre_pend: got %h expected %h", got, exp); end
    @(negedge clk);
    reset = 1'b0;                  // no clock edge until release
    #1;
    exp_q.push_back(32'h1);
    got = {31'h0, nIRQ};
    exp = exp_q.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL mid_nirq: got %h expected %h", got, exp); end
    reset = 1'b1;
    foreach (addrs[i]) begin
      exp_q.push_back(32'h0);
      bus_read(addrs[i], got);
      exp = exp_q.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL mid_reg_%0h: got %h expected %h", addrs[i], got, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_edge_latency();
    test_priority();
    test_collision();
    test_level();
    test_mask_swset();
    test_pol();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
